// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection sequencer.
// TLEN_W must match the width of the shared timer's t_length input.
package traffic_pkg;

  localparam int TLEN_W = 5;

  typedef enum logic [2:0] {
    ALL_RED_A = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALL_RED_B = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    PED_WALK  = 3'd6
  } phase_t;

  localparam logic [TLEN_W-1:0] DEF_T_GREEN  = 5'd10;
  localparam logic [TLEN_W-1:0] DEF_T_YELLOW = 5'd3;
  localparam logic [TLEN_W-1:0] DEF_T_ALLRED = 5'd2;
  localparam logic [TLEN_W-1:0] DEF_T_WALK   = 5'd8;

endpackage

// File: rtl/traffic_light_ctrl_ped_req_latch.sv
// Sticky pedestrian request flag.
// Ports: clk, reset (async, active-high), set (button), clear (walk served),
//        pending (request outstanding). A set on the same edge as a clear wins,
//        so a press coinciding with walk entry is not lost.
module ped_req_latch (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic clear,
  output logic pending
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (set) begin
      pending <= 1'b1;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Intersection sequencer: steps NS/EW vehicle phases through green, yellow and
// all-red clearance, inserting a pedestrian walk on request. Drives the shared
// timer (t_start/t_length) and advances on its expiry (t_done).
// Ports:
//   clk, reset          clock, async active-high reset
//   car_ns, car_ew      vehicle presence (level), sampled only at phase end
//   ped_req             pedestrian button (pulse or level)
//   t_done, t_flicker   timer expiry / flicker from the shared timer
//   t_start, t_length   one-cycle timer start pulse and its duration
//   ns_*/ew_* lamps     one-hot per direction
//   ped_walk, ped_flash walk lamp and its end-of-walk flash
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter logic [TLEN_W-1:0] T_GREEN  = DEF_T_GREEN,
  parameter logic [TLEN_W-1:0] T_YELLOW = DEF_T_YELLOW,
  parameter logic [TLEN_W-1:0] T_ALLRED = DEF_T_ALLRED,
  parameter logic [TLEN_W-1:0] T_WALK   = DEF_T_WALK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              car_ns,
  input  logic              car_ew,
  input  logic              ped_req,
  input  logic              t_done,
  input  logic              t_flicker,
  output logic              t_start,
  output logic [TLEN_W-1:0] t_length,
  output logic              ns_red,
  output logic              ns_yellow,
  output logic              ns_green,
  output logic              ew_red,
  output logic              ew_yellow,
  output logic              ew_green,
  output logic              ped_walk,
  output logic              ped_flash
);

  phase_t state;
  phase_t next_phase;
  logic   ped_pending;
  logic   advance;
  logic   ped_clear;

  function automatic logic [TLEN_W-1:0] dur(input phase_t p);
    case (p)
      NS_GREEN, EW_GREEN:   dur = T_GREEN;
      NS_YELLOW, EW_YELLOW: dur = T_YELLOW;
      PED_WALK:             dur = T_WALK;
      default:              dur = T_ALLRED;
    endcase
  endfunction

  // A t_done seen while our own start pulse is still out belongs to the
  // previous timing run and must not advance the phase.
  assign advance = t_done & ~t_start;

  always_comb begin
    next_phase = ALL_RED_A;
    case (state)
      ALL_RED_A: next_phase = ped_pending ? PED_WALK : NS_GREEN;
      PED_WALK:  next_phase = NS_GREEN;
      NS_GREEN:  next_phase = (car_ew | ped_pending) ? NS_YELLOW : NS_GREEN;
      NS_YELLOW: next_phase = ALL_RED_B;
      ALL_RED_B: next_phase = EW_GREEN;
      EW_GREEN:  next_phase = (car_ns | ped_pending) ? EW_YELLOW : EW_GREEN;
      EW_YELLOW: next_phase = ALL_RED_A;
      default:   next_phase = ALL_RED_A;
    endcase
  end

  assign ped_clear = advance & (next_phase == PED_WALK);

  ped_req_latch u_ped_req_latch (
    .clk     (clk),
    .reset   (reset),
    .set     (ped_req),
    .clear   (ped_clear),
    .pending (ped_pending)
  );

  // Phase register: every entry (including re-entry of the same green)
  // reissues a start pulse and reloads the lamps from the new phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ALL_RED_A;
      t_start   <= 1'b1;
      t_length  <= T_ALLRED;
      ns_red    <= 1'b1;
      ns_yellow <= 1'b0;
      ns_green  <= 1'b0;
      ew_red    <= 1'b1;
      ew_yellow <= 1'b0;
      ew_green  <= 1'b0;
      ped_walk  <= 1'b0;
    end else if (advance) begin
      state     <= next_phase;
      t_start   <= 1'b1;
      t_length  <= dur(next_phase);
      ns_red    <= !(next_phase inside {NS_GREEN, NS_YELLOW});
      ns_yellow <= (next_phase == NS_YELLOW);
      ns_green  <= (next_phase == NS_GREEN);
      ew_red    <= !(next_phase inside {EW_GREEN, EW_YELLOW});
      ew_yellow <= (next_phase == EW_YELLOW);
      ew_green  <= (next_phase == EW_GREEN);
      ped_walk  <= (next_phase == PED_WALK);
    end else begin
      t_start   <= 1'b0;
    end
  end

  assign ped_flash = ped_walk & t_flicker;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       car_ns = 1'b0;
  logic       car_ew = 1'b0;
  logic       ped_req = 1'b0;
  logic       t_done = 1'b0;
  logic       t_flicker = 1'b0;
  logic       t_start;
  logic [4:0] t_length;
  logic       ns_red, ns_yellow, ns_green;
  logic       ew_red, ew_yellow, ew_green;
  logic       ped_walk, ped_flash;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic prev_ts = 1'b0;

  // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
  logic [6:0] lamps;
  assign lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk};

  localparam logic [6:0] L_ALLRED = 7'b100_100_0;
  localparam logic [6:0] L_NSG    = 7'b001_100_0;
  localparam logic [6:0] L_NSY    = 7'b010_100_0;
  localparam logic [6:0] L_EWG    = 7'b100_001_0;
  localparam logic [6:0] L_EWY    = 7'b100_010_0;
  localparam logic [6:0] L_WALK   = 7'b100_100_1;

  traffic_light_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .car_ns    (car_ns),
    .car_ew    (car_ew),
    .ped_req   (ped_req),
    .t_done    (t_done),
    .t_flicker (t_flicker),
    .t_start   (t_start),
    .t_length  (t_length),
    .ns_red    (ns_red),
    .ns_yellow (ns_yellow),
    .ns_green  (ns_green),
    .ew_red    (ew_red),
    .ew_yellow (ew_yellow),
    .ew_green  (ew_green),
    .ped_walk  (ped_walk),
    .ped_flash (ped_flash)
  );

  always #5 clk = ~clk;

  // Continuous safety checks, sampled away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk_cnt++;
      if ((ns_green | ns_yellow) && (ew_green | ew_yellow))
        $display("FAIL conflict_lamps got %b required no double go", lamps);
      else
        pass_cnt++;
      chk_cnt++;
      if (prev_ts && t_start)
        $display("FAIL t_start_twice got 1 on consecutive cycles required single pulse");
      else
        pass_cnt++;
      prev_ts = t_start;
    end else begin
      prev_ts = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One quiet cycle (start pulse drops), then a timer expiry edge.
  task automatic expire();
    tick();
    t_done = 1'b1;
    tick();
    t_done = 1'b0;
  endtask

  // From a just-entered NS_GREEN, cycle round to ALL_RED_A with cars on both roads.
  task automatic to_all_red_a();
    car_ns = 1'b1;
    car_ew = 1'b1;
    for (int i = 0; i < 5; i++) expire();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    chk_cnt++; if (t_start !== 1'b1) $display("FAIL rst_tstart got %b required 1", t_start); else pass_cnt++;
    chk_cnt++; if (t_length !== 5'd2) $display("FAIL rst_tlen got %0d required 2", t_length); else pass_cnt++;
    chk_cnt++; if (lamps !== L_ALLRED) $display("FAIL rst_lamps got %b required %b", lamps, L_ALLRED); else pass_cnt++;
    chk_cnt++; if (ped_flash !== 1'b0) $display("FAIL rst_flash got %b required 0", ped_flash); else pass_cnt++;
    #49;
    reset = 1'b0;
    #1;
    chk_cnt++; if (t_start !== 1'b1) $display("FAIL rel_tstart got %b required 1", t_start); else pass_cnt++;
    tick();
    chk_cnt++; if (t_start !== 1'b0) $display("FAIL first_pulse_end got %b required 0", t_start); else pass_cnt++;
    tick(); tick();
    chk_cnt++; if (lamps !== L_ALLRED) $display("FAIL allred_hold got %b required %b", lamps, L_ALLRED); else pass_cnt++;
    t_done = 1'b1;
    tick();
    t_done = 1'b0;
    chk_cnt++; if (lamps !== L_NSG) $display("FAIL to_nsg got %b required %b", lamps, L_NSG); else pass_cnt++;
    chk_cnt++; if (t_start !== 1'b1 || t_length !== 5'd10) $display("FAIL nsg_start got %b/%0d required 1/10", t_start, t_length); else pass_cnt++;
  endtask

  task automatic test_ns_green_hold();
    car_ew = 1'b0;
    expire();
    chk_cnt++; if (t_start !== 1'b1 || t_length !== 5'd10) $display("FAIL nsg_reenter got %b/%0d required 1/10", t_start, t_length); else pass_cnt++;
    chk_cnt++; if (lamps !== L_NSG) $display("FAIL nsg_stay got %b required %b", lamps, L_NSG); else pass_cnt++;
    car_ew = 1'b1;
    expire();
    chk_cnt++; if (lamps !== L_NSY || t_length !== 5'd3) $display("FAIL to_nsy got %b/%0d required %b/3", lamps, t_length, L_NSY); else pass_cnt++;
    expire();
    chk_cnt++; if (lamps !== L_ALLRED || t_length !== 5'd2) $display("FAIL to_arb got %b/%0d required %b/2", lamps, t_length, L_ALLRED); else pass_cnt++;
    expire();
    chk_cnt++; if (lamps !== L_EWG || t_length !== 5'd10) $display("FAIL to_ewg got %b/%0d required %b/10", lamps, t_length, L_EWG); else pass_cnt++;
    car_ew = 1'b0;
    car_ns = 1'b0;
  endtask

  task automatic test_ped_walk();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    expire();
    chk_cnt++; if (lamps !== L_EWY || t_length !== 5'd3) $display("FAIL ped_to_ewy got %b/%0d required %b/3", lamps, t_length, L_EWY); else pass_cnt++;
    expire();
    chk_cnt++; if (lamps !== L_ALLRED || t_length !== 5'd2) $display("FAIL ped_to_ara got %b/%0d required %b/2", lamps, t_length, L_ALLRED); else pass_cnt++;
    expire();
    chk_cnt++; if (lamps !== L_WALK || t_length !== 5'd8) $display("FAIL to_walk got %b/%0d required %b/8", lamps, t_length, L_WALK); else pass_cnt++;
    t_flicker = 1'b1;
    #1;
    chk_cnt++; if (ped_flash !== 1'b1) $display("FAIL flash_on got %b required 1", ped_flash); else pass_cnt++;
    t_flicker = 1'b0;
    #1;
    chk_cnt++; if (ped_flash !== 1'b0) $display("FAIL flash_off got %b required 0", ped_flash); else pass_cnt++;
    expire();
    chk_cnt++; if (lamps !== L_NSG || t_length !== 5'd10) $display("FAIL walk_to_nsg got %b/%0d required %b/10", lamps, t_length, L_NSG); else pass_cnt++;
    t_flicker = 1'b1;
    #1;
    chk_cnt++; if (ped_flash !== 1'b0) $display("FAIL flash_outside got %b required 0", ped_flash); else pass_cnt++;
    t_flicker = 1'b0;
    to_all_red_a();
    expire();
    chk_cnt++; if (lamps !== L_NSG) $display("FAIL ped_cleared got %b required %b", lamps, L_NSG); else pass_cnt++;
  endtask

  task automatic test_ped_set_wins();
    to_all_red_a();
    ped_req = 1'b1;
    expire();
    ped_req = 1'b0;
    chk_cnt++; if (lamps !== L_WALK) $display("FAIL sw_walk1 got %b required %b", lamps, L_WALK); else pass_cnt++;
    expire();
    to_all_red_a();
    expire();
    chk_cnt++; if (lamps !== L_WALK || t_length !== 5'd8) $display("FAIL sw_walk2 got %b/%0d required %b/8", lamps, t_length, L_WALK); else pass_cnt++;
    expire();
    to_all_red_a();
    expire();
    chk_cnt++; if (lamps !== L_NSG) $display("FAIL sw_cleared got %b required %b", lamps, L_NSG); else pass_cnt++;
  endtask

  task automatic test_stale_done();
    car_ew = 1'b1;
    chk_cnt++; if (t_start !== 1'b1) $display("FAIL stale_pre got %b required 1", t_start); else pass_cnt++;
    t_done = 1'b1;
    tick();
    t_done = 1'b0;
    chk_cnt++; if (lamps !== L_NSG || t_start !== 1'b0) $display("FAIL stale_ignored got %b/%b required %b/0", lamps, t_start, L_NSG); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_cnt++; if (lamps !== L_ALLRED) $display("FAIL mid_rst_lamps got %b required %b", lamps, L_ALLRED); else pass_cnt++;
    chk_cnt++; if (t_start !== 1'b1 || t_length !== 5'd2) $display("FAIL mid_rst_timer got %b/%0d required 1/2", t_start, t_length); else pass_cnt++;
    #10;
    reset = 1'b0;
    tick();
    chk_cnt++; if (t_start !== 1'b0 || lamps !== L_ALLRED) $display("FAIL mid_rel got %b/%b required 0/%b", t_start, lamps, L_ALLRED); else pass_cnt++;
    expire();
    chk_cnt++; if (lamps !== L_NSG || t_length !== 5'd10) $display("FAIL mid_restart got %b/%0d required %b/10", lamps, t_length, L_NSG); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_ns_green_hold();
    test_ped_walk();
    test_ped_set_wins();
    test_stale_done();
    test_reset_mid();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
